// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg -- shared definitions for the debug responder.
//   * Debug command codes carried on dbg_bus.cmd (8 bit).
//   * Response words returned on dbg_bus.data_dut_dbg.
//   * FSM state encoding used by dbg_responder.
// No ports (package).
// -----------------------------------------------------------------------------
package dbg_pkg;

    localparam logic [7:0] DBG_CMD_NONE   = 8'h00;
    localparam logic [7:0] DBG_CMD_HALT   = 8'h01;
    localparam logic [7:0] DBG_CMD_RESUME = 8'h02;
    localparam logic [7:0] DBG_CMD_RD_REG = 8'h03;
    localparam logic [7:0] DBG_CMD_WR_REG = 8'h04;

    localparam logic [31:0] DBG_RSP_OK         = 32'h0000_0000;
    localparam logic [31:0] DBG_RSP_TIMEOUT    = 32'h0000_0001;
    localparam logic [31:0] DBG_RSP_NOT_HALTED = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_RESUME,
        ST_RF_READ,
        ST_RF_WRITE,
        ST_DONE,
        ST_WAIT_IDLE
    } dbg_state_t;

endpackage

// File: rtl/dbg_intf.sv
// -----------------------------------------------------------------------------
// dbg_intf -- link between the debug module and the core-side responder.
//   cmd          [7:0]  command, 0 = none          (debug module -> core)
//   addr         [31:0] register index, [4:0] used (debug module -> core)
//   data_dbg_dut [31:0] register write data        (debug module -> core)
//   data_dut_dbg [31:0] response data              (core -> debug module)
//   dut_done            one-cycle completion pulse (core -> debug module)
// Modports: dut (responder side), dbg (debug module side).
// -----------------------------------------------------------------------------
interface dbg_intf;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data_dbg_dut;
    logic [31:0] data_dut_dbg;
    logic        dut_done;

    modport dut (
        input  cmd,
        input  addr,
        input  data_dbg_dut,
        output data_dut_dbg,
        output dut_done
    );

    modport dbg (
        output cmd,
        output addr,
        output data_dbg_dut,
        input  data_dut_dbg,
        input  dut_done
    );
endinterface

// File: rtl/dbg_responder.sv
// -----------------------------------------------------------------------------
// dbg_responder -- executes debug commands against the core: halt / resume
// the pipeline and read / write the register file while halted.
//
// Ports:
//   clk          in   clock, rising edge
//   rstn_i       in   asynchronous active-low reset
//   dbg_bus      dbg_intf.dut  command / response link
//   halt_req_o   out  level stall request to the core pipeline
//   halted_i     in   core drained and stalled
//   rf_raddr_o   out  [4:0]  register-file read address (0 when idle)
//   rf_rdata_i   in   [31:0] register-file read data (combinational)
//   rf_we_o      out  register-file write enable (one-cycle pulse)
//   rf_waddr_o   out  [4:0]  register-file write address
//   rf_wdata_o   out  [31:0] register-file write data
//
// Parameter HALT_TIMEOUT: halt-acknowledge wait limit in cycles.
// Build option: define DBG_HALT_TIMEOUT_EN to bound the HALT wait; a timeout
// completes the command with DBG_RSP_TIMEOUT while keeping halt_req_o high.
// Without it, HALT waits indefinitely and no counter is built.
// -----------------------------------------------------------------------------
module dbg_responder
    import dbg_pkg::*;
#(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn_i,
    dbg_intf.dut        dbg_bus,
    output logic        halt_req_o,
    input  logic        halted_i,
    output logic [4:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    if (HALT_TIMEOUT < 1) begin : g_bad_timeout
        $error("dbg_responder: HALT_TIMEOUT must be at least 1");
    end

`ifdef DBG_HALT_TIMEOUT_EN
    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`endif

    dbg_state_t  state;
    logic        done_q;
    logic [31:0] data_q;
    logic        rf_ok;      // core was halted when the register command was accepted
    logic [4:0]  idx;
    logic        unused_addr_bits;

    assign idx              = dbg_bus.addr[4:0];
    assign unused_addr_bits = &{1'b0, dbg_bus.addr[31:5]};

    assign dbg_bus.dut_done     = done_q;
    assign dbg_bus.data_dut_dbg = data_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= ST_IDLE;
            done_q     <= 1'b0;
            data_q     <= DBG_RSP_OK;
            halt_req_o <= 1'b0;
            rf_ok      <= 1'b0;
            rf_raddr_o <= 5'd0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= 32'd0;
`ifdef DBG_HALT_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            // Pulsed outputs default low; only the entering transition raises them.
            done_q     <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_raddr_o <= 5'd0;

            case (state)
                ST_IDLE: begin
                    case (dbg_bus.cmd)
                        DBG_CMD_NONE: begin
                            state <= ST_IDLE;
                        end
                        DBG_CMD_HALT: begin
                            halt_req_o <= 1'b1;
`ifdef DBG_HALT_TIMEOUT_EN
                            cnt        <= '0;
`endif
                            state      <= ST_HALT;
                        end
                        DBG_CMD_RESUME: begin
                            halt_req_o <= 1'b0;
                            state      <= ST_RESUME;
                        end
                        DBG_CMD_RD_REG: begin
                            // Address is only presented when the core is halted.
                            rf_ok      <= halted_i;
                            rf_raddr_o <= halted_i ? idx : 5'd0;
                            state      <= ST_RF_READ;
                        end
                        DBG_CMD_WR_REG: begin
                            // x0 is hard-wired: never issue a write to index 0.
                            rf_ok      <= halted_i;
                            rf_we_o    <= halted_i && (idx != 5'd0);
                            rf_waddr_o <= idx;
                            rf_wdata_o <= dbg_bus.data_dbg_dut;
                            state      <= ST_RF_WRITE;
                        end
                        default: begin
                            data_q <= DBG_RSP_OK;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    endcase
                end

                ST_HALT: begin
                    if (halted_i) begin
                        data_q <= DBG_RSP_OK;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
`ifdef DBG_HALT_TIMEOUT_EN
                    else if (cnt == CNT_W'(HALT_TIMEOUT)) begin
                        // Give up waiting but leave the stall request asserted.
                        data_q <= DBG_RSP_TIMEOUT;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                ST_RESUME: begin
                    if (!halted_i) begin
                        data_q <= DBG_RSP_OK;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                ST_RF_READ: begin
                    // rf_raddr_o still holds the index this cycle.
                    if (!rf_ok)
                        data_q <= DBG_RSP_NOT_HALTED;
                    else if (rf_raddr_o == 5'd0)
                        data_q <= 32'd0;
                    else
                        data_q <= rf_rdata_i;
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end

                ST_RF_WRITE: begin
                    data_q <= rf_ok ? DBG_RSP_OK : DBG_RSP_NOT_HALTED;
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end

                ST_DONE: begin
                    // A command still present here has already executed once.
                    state <= (dbg_bus.cmd == DBG_CMD_NONE) ? ST_IDLE : ST_WAIT_IDLE;
                end

                ST_WAIT_IDLE: begin
                    if (dbg_bus.cmd == DBG_CMD_NONE)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_responder.sv
// -----------------------------------------------------------------------------
// tb_dbg_responder -- directed, table-driven bench for dbg_responder.
// Register-access vectors run from a table; halt / resume / unknown command /
// reset-abort / timeout (when DBG_HALT_TIMEOUT_EN is defined) are hand sequences.
// -----------------------------------------------------------------------------
module tb_dbg_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        halted;
    logic        halt_req;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    dbg_intf bus ();

    dbg_responder #(.HALT_TIMEOUT(4)) dut (
        .clk        (clk),
        .rstn_i     (rstn),
        .dbg_bus    (bus.dut),
        .halt_req_o (halt_req),
        .halted_i   (halted),
        .rf_raddr_o (rf_raddr),
        .rf_rdata_i (rf_rdata),
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata)
    );

    always #5 clk = ~clk;

    // Register file model: every register reads as CAFE_00xx with xx = index.
    assign rf_rdata = 32'hCAFE_0000 | {27'd0, rf_raddr};

    typedef struct {
        string       name;
        logic        halted;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  exp_raddr;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register command: sampled at cycle 0, RF access visible in cycle 1,
    // dut_done in cycle 2, then the command is dropped.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        halted           = v.halted;
        bus.cmd          = v.cmd;
        bus.addr         = v.addr;
        bus.data_dbg_dut = v.wdata;
        @(negedge clk);
        chk({v.name, " c1 raddr"}, 32'(rf_raddr), 32'(v.exp_raddr));
        chk({v.name, " c1 we"}, 32'(rf_we), 32'(v.exp_we));
        chk({v.name, " c1 done"}, 32'(bus.dut_done), 32'd0);
        if (v.exp_we) begin
            chk({v.name, " waddr"}, 32'(rf_waddr), 32'(v.addr[4:0]));
            chk({v.name, " wdata"}, rf_wdata, v.wdata);
        end
        @(negedge clk);
        chk({v.name, " c2 done"}, 32'(bus.dut_done), 32'd1);
        chk({v.name, " c2 data"}, bus.data_dut_dbg, v.exp_data);
        chk({v.name, " c2 we"}, 32'(rf_we), 32'd0);
        chk({v.name, " c2 raddr"}, 32'(rf_raddr), 32'd0);
        bus.cmd = 8'h00;
        @(negedge clk);
        chk({v.name, " c3 done"}, 32'(bus.dut_done), 32'd0);
        chk({v.name, " c3 data held"}, bus.data_dut_dbg, v.exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"rd5",      1'b1, 8'h03, 32'd5,          32'd0,          5'd5,  1'b0, 32'hCAFE_0005};
        vecs[1] = '{"rd0",      1'b1, 8'h03, 32'd0,          32'd0,          5'd0,  1'b0, 32'h0000_0000};
        vecs[2] = '{"rd31",     1'b1, 8'h03, 32'd31,         32'd0,          5'd31, 1'b0, 32'hCAFE_001F};
        vecs[3] = '{"rdhi",     1'b1, 8'h03, 32'hFFFF_FFE9,  32'd0,          5'd9,  1'b0, 32'hCAFE_0009};
        vecs[4] = '{"wr7",      1'b1, 8'h04, 32'd7,          32'h1234_5678,  5'd0,  1'b1, 32'h0000_0000};
        vecs[5] = '{"wr0",      1'b1, 8'h04, 32'd0,          32'h1234_5678,  5'd0,  1'b0, 32'h0000_0000};
        vecs[6] = '{"rdrun",    1'b0, 8'h03, 32'd5,          32'd0,          5'd0,  1'b0, 32'hFFFF_FFFF};
        vecs[7] = '{"wrrun",    1'b0, 8'h04, 32'd7,          32'hA5A5_5A5A,  5'd0,  1'b0, 32'hFFFF_FFFF};

        rstn             = 1'b0;
        halted           = 1'b0;
        bus.cmd          = 8'h00;
        bus.addr         = 32'd0;
        bus.data_dbg_dut = 32'd0;
        #12;
        chk("rst done", 32'(bus.dut_done), 32'd0);
        chk("rst data", bus.data_dut_dbg, 32'd0);
        chk("rst halt_req", 32'(halt_req), 32'd0);
        chk("rst we", 32'(rf_we), 32'd0);
        chk("rst raddr", 32'(rf_raddr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle done", 32'(bus.dut_done), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Unknown command completes directly with data 0.
        @(negedge clk);
        bus.cmd = 8'h55;
        @(negedge clk);
        chk("unk done", 32'(bus.dut_done), 32'd1);
        chk("unk data", bus.data_dut_dbg, 32'd0);
        bus.cmd = 8'h00;
        @(negedge clk);
        chk("unk done low", 32'(bus.dut_done), 32'd0);

        // Leave non-zero data so the halt response is distinguishable.
        run_vec(vecs[0]);

        // HALT with halted_i arriving 3 cycles later; command held afterwards.
        @(negedge clk);
        halted  = 1'b0;
        bus.cmd = 8'h01;
        @(negedge clk);
        chk("halt req", 32'(halt_req), 32'd1);
        chk("halt wait1", 32'(bus.dut_done), 32'd0);
        @(negedge clk);
        chk("halt wait2", 32'(bus.dut_done), 32'd0);
        @(negedge clk);
        chk("halt wait3", 32'(bus.dut_done), 32'd0);
        halted = 1'b1;
        @(negedge clk);
        chk("halt done", 32'(bus.dut_done), 32'd1);
        chk("halt data", bus.data_dut_dbg, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt held no repeat", 32'(bus.dut_done), 32'd0);
        end
        bus.cmd = 8'h00;
        @(negedge clk);
        chk("halt req sticky", 32'(halt_req), 32'd1);

        // RESUME while halted: done once the core reports running.
        bus.cmd = 8'h02;
        @(negedge clk);
        chk("resume req clr", 32'(halt_req), 32'd0);
        chk("resume wait", 32'(bus.dut_done), 32'd0);
        @(negedge clk);
        chk("resume wait2", 32'(bus.dut_done), 32'd0);
        halted = 1'b0;
        @(negedge clk);
        chk("resume done", 32'(bus.dut_done), 32'd1);
        bus.cmd = 8'h00;
        @(negedge clk);

        // RESUME while already running: done on the next cycle.
        bus.cmd = 8'h02;
        @(negedge clk);
        chk("resume run c1", 32'(bus.dut_done), 32'd0);
        @(negedge clk);
        chk("resume run c2", 32'(bus.dut_done), 32'd1);
        bus.cmd = 8'h00;
        @(negedge clk);

        // HALT while already halted: done on the next cycle.
        halted  = 1'b1;
        bus.cmd = 8'h01;
        @(negedge clk);
        chk("halt2 c1", 32'(bus.dut_done), 32'd0);
        @(negedge clk);
        chk("halt2 c2", 32'(bus.dut_done), 32'd1);
        bus.cmd = 8'h00;
        @(negedge clk);

        // Reset in the middle of a HALT wait.
        halted  = 1'b0;
        bus.cmd = 8'h01;
        repeat (2) @(negedge clk);
        chk("mid halt req", 32'(halt_req), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst halt req", 32'(halt_req), 32'd0);
        chk("rst halt done", 32'(bus.dut_done), 32'd0);
        chk("rst halt data", bus.data_dut_dbg, 32'd0);
        bus.cmd = 8'h00;
        @(negedge clk);
        rstn = 1'b1;
        run_vec(vecs[6]);

        // Reset while a register write is in flight.
        @(negedge clk);
        halted           = 1'b1;
        bus.cmd          = 8'h04;
        bus.addr         = 32'd7;
        bus.data_dbg_dut = 32'h1234_5678;
        @(negedge clk);
        chk("mid wr we", 32'(rf_we), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rst wr we", 32'(rf_we), 32'd0);
        chk("rst wr done", 32'(bus.dut_done), 32'd0);
        bus.cmd = 8'h00;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post rst we", 32'(rf_we), 32'd0);
        chk("post rst done", 32'(bus.dut_done), 32'd0);
        chk("post rst halt_req", 32'(halt_req), 32'd0);

`ifdef DBG_HALT_TIMEOUT_EN
        begin
            logic seen;
            seen    = 1'b0;
            halted  = 1'b0;
            bus.cmd = 8'h01;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.dut_done) seen = 1'b1;
            end
            chk("to done seen", 32'(seen), 32'd1);
            chk("to data", bus.data_dut_dbg, 32'h0000_0001);
            chk("to halt_req", 32'(halt_req), 32'd1);
            bus.cmd = 8'h00;
            @(negedge clk);
            chk("to halt_req kept", 32'(halt_req), 32'd1);
            bus.cmd = 8'h02;
            @(negedge clk);
            chk("to resume clr", 32'(halt_req), 32'd0);
            @(negedge clk);
            chk("to resume done", 32'(bus.dut_done), 32'd1);
            bus.cmd = 8'h00;
            @(negedge clk);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_responder.md
DBG_RESPONDER -- requirements
Module: dbg_responder

Interface
REQ-001 Parameter: HALT_TIMEOUT, default 255, max cycles to wait for halt acknowledge (used only with DBG_HALT_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 dbg_bus  dbg_intf.dut modport  -  debug link from the debug module.
REQ-005 dbg_bus.cmd  in  8  command; 0 = none.
REQ-006 dbg_bus.addr  in  32  register index; only [4:0] used.
REQ-007 dbg_bus.data_dbg_dut  in  32  register write data.
REQ-008 dbg_bus.data_dut_dbg  out  32  response data, valid while dut_done=1.
REQ-009 dbg_bus.dut_done  out  1  one-cycle completion pulse.
REQ-010 halt_req_o  out  1  stall request to the core pipeline (level).
REQ-011 halted_i  in  1  core drained and stalled.
REQ-012 rf_raddr_o  out  5  register-file read address; rf_rdata_i is combinational from it.
REQ-013 rf_rdata_i  in  32  register-file read data.
REQ-014 rf_we_o / rf_waddr_o / rf_wdata_o  out  1/5/32  register-file write port.

Function
REQ-015 FSM states: IDLE, HALT, RESUME, RF_READ, RF_WRITE, DONE, WAIT_IDLE.
REQ-016 IDLE decodes cmd: 01 -> HALT, 02 -> RESUME, 03 -> RF_READ, 04 -> RF_WRITE, other nonzero -> DONE with data 0, 00 stays IDLE.
REQ-017 dut_done is a registered decode of state==DONE, asserted for exactly one cycle, with no combinational path from cmd.
REQ-018 Leaving DONE: cmd==0 -> IDLE; otherwise -> WAIT_IDLE, held until cmd==0 (one execution per command).
REQ-019 HALT: halt_req_o set (sticky register); -> DONE in the first cycle halted_i=1; data_dut_dbg=0.
REQ-020 HALT while already halted (halt_req_o=1 and halted_i=1): DONE on the next cycle.
REQ-021 RESUME: halt_req_o cleared on entry; -> DONE in the first cycle halted_i=0; already running gives DONE on the next cycle.
REQ-022 RF_READ: rf_raddr_o=addr[4:0] for one cycle; rf_rdata_i captured into the data register; index 0 returns 0 and ignores rf_rdata_i; -> DONE.
REQ-023 RF_WRITE: rf_we_o=1 for exactly one cycle with addr[4:0] and data_dbg_dut; index 0 suppresses rf_we_o; -> DONE.
REQ-024 Latency: register command sampled in IDLE at cycle 0 -> RF cycle 1 -> dut_done at cycle 2.
REQ-025 Register access while not halted (halted_i=0): no RF access, DONE with data 32'hFFFF_FFFF.
REQ-026 rf_we_o=0 and rf_raddr_o=0 in every state except their own.
REQ-027 data_dut_dbg holds its value until the next command completes.

Reset
REQ-028 On rstn_i low, asynchronously: state=IDLE; dut_done=0; data_dut_dbg=0; halt_req_o=0; rf_we_o=0; timeout counter=0.
REQ-029 Reset during any operation abandons it: no dut_done, no RF write, core released.

Configuration
REQ-030 DBG_HALT_TIMEOUT_EN defined: a counter runs in HALT.
- Counter reaching HALT_TIMEOUT without halted_i forces DONE with data 32'h0000_0001.
- halt_req_o stays asserted after the timeout.
- Counter clears on HALT entry.
REQ-031 DBG_HALT_TIMEOUT_EN undefined: HALT waits indefinitely; no counter logic exists.

Structure
REQ-032 Package dbg_pkg holds:
- command constants DBG_CMD_NONE/HALT/RESUME/RD_REG/WR_REG (8 bit);
- response constants DBG_RSP_OK=0, DBG_RSP_TIMEOUT=1, DBG_RSP_NOT_HALTED=FFFF_FFFF;
- the FSM state enum.
REQ-033 No sub-module; single FSM plus data register and optional counter.

Verification
REQ-034 cmd=01, halted_i rises 3 cycles later -> halt_req_o=1 next cycle; dut_done one pulse, one cycle after halted_i; data=0.
REQ-035 Halted; cmd=03, addr=5, rf_rdata_i=32'hCAFE_0005 -> rf_raddr_o=5; dut_done at cycle 2 with data CAFE_0005; addr=0 gives 0.
REQ-036 Halted; cmd=04, addr=7, data=32'h1234_5678 -> one rf_we_o pulse with waddr 7; addr=0 -> no rf_we_o; dut_done in both cases.
REQ-037 Running; cmd=03 -> no RF access; dut_done with FFFF_FFFF; cmd held after done -> WAIT_IDLE, no second pulse.
REQ-038 With DBG_HALT_TIMEOUT_EN, HALT_TIMEOUT=4, halted_i stuck 0 -> dut_done after timeout with data 1, halt_req_o remains 1; cmd=02 then clears it.
REQ-039 rstn_i low mid-HALT and mid-RF_WRITE -> halt_req_o=0, rf_we_o=0, dut_done=0, state IDLE immediately.
